grf_wport_arbiter: RTL
======================

GRF_WPORT_ARBITER -- requirements
Module: grf_wport_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive cycles a held MDU write is denied before it is forced; legal range is 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, the reset: synchronous and active-low (0 = reset).
REQ-004 SHALL have ports wb_valid (in, 1), wb_ready (out, 1), wb_addr (in, 5), wb_data (in, 32) and wb_pc (in, 32), forming the writeback-stage write request.
REQ-005 SHALL have ports md_valid (in, 1), md_ready (out, 1), md_addr (in, 5), md_data (in, 32) and md_pc (in, 32), forming the multiply/divide-unit write request.
REQ-006 SHALL have ports RegWrite (out, 1), RegAddr (out, 5), RegData (out, 32) and PC (out, 32), which drive the GRF write port.
REQ-007 SHALL have port busy, output, 32: bit i is 1 while any held entry targets register i; bit 0 is always 0.

Function
REQ-008 SHALL hold one entry per requester (addr, data, pc, valid); a request is accepted on an edge where valid && ready.
REQ-009 SHALL drive x_ready = !held_x || granted_x, so one entry can drain and refill on the same edge.
REQ-010 SHALL accept requests with addr 0 (ready honoured) and discard them, without holding them, setting busy or writing.
REQ-011 SHALL grant at most one held entry per cycle; the outputs are combinational from the granted entry, and RegWrite=1 only when a grant exists.
REQ-012 SHALL free the granted entry at the end of its grant cycle, so write latency is exactly one cycle from acceptance when uncontended.
REQ-013 SHALL implement a two-state FSM: WB_PRIO, where WB wins when both are held, and MD_FORCE, where MD wins.
REQ-014 SHALL increment a 4-bit starve counter each cycle MD is held but not granted, clear it when MD is granted or not held, and enter MD_FORCE when it reaches STARVE_LIMIT.
REQ-015 SHALL return from MD_FORCE to WB_PRIO on the edge MD is granted.
REQ-016 SHALL give an address-match override priority over REQ-013: when both entries hold the same nonzero addr, the earlier-accepted entry is granted first.
REQ-017 SHALL treat same-edge acceptance of both requests as WB earlier for the purposes of REQ-016.
REQ-018 SHALL, when only one entry is held, grant it regardless of FSM state.
REQ-019 SHALL update busy on the same edge as holding changes, so busy is registered and drops on the edge the write commits.

Reset
REQ-020 SHALL, while reset=0 at an edge, clear both entries, the counter and the age flag, and enter WB_PRIO.
REQ-021 SHALL force wb_ready=0, md_ready=0, RegWrite=0, RegAddr=0, RegData=0, PC=0 and busy=0 during reset.
REQ-022 SHALL drop entries held when reset is asserted mid-operation without ever writing them, and drive both readys to 1 on the first cycle after release.

Configuration
REQ-023 SHALL, with macro GRF_ARB_TRACE_EN defined, $display every granted write as "%d@%h: $%d <= %h" using $time, PC, RegAddr and RegData.
REQ-024 SHALL, without GRF_ARB_TRACE_EN, emit no display output and keep identical functional behaviour.

Verification
REQ-025 SHALL cover a lone WB request: wb addr=5, data=32'h1234, pc=32'h3000 -> next cycle RegWrite=1, RegAddr=5, RegData=32'h1234, PC=32'h3000, busy[5]=1 for exactly that cycle.
REQ-026 SHALL cover contention: WB and MD each issue one write to different registers on the same edge -> WB is written first and MD in the following cycle.
REQ-027 SHALL cover starvation: MD is held while WB streams back-to-back with STARVE_LIMIT=4 -> MD is granted on the 5th held cycle, and WB is stalled (wb_ready=0) for that one cycle.
REQ-028 SHALL cover ordering: MD to addr 9 is accepted one cycle before WB to addr 9 -> MD data is written first, then WB data, and busy[9] clears after the second write.
REQ-029 SHALL cover the zero register and reset: a WB write to addr 0 gives wb_ready=1 and no RegWrite; reset=0 with both entries held gives no writes, then both readys are 1 after release.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// Two-requester arbiter (writeback stage, multiply/divide unit) for a single GRF write port.
// Optional write trace: define GRF_ARB_TRACE_EN to print every granted write.
module grf_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc,
    output logic        RegWrite,
    output logic [4:0]  RegAddr,
    output logic [31:0] RegData,
    output logic [31:0] PC,
    output logic [31:0] busy
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned NR = 32;

    localparam logic [0:0] WB_PRIO  = 1'b0;
    localparam logic [0:0] MD_FORCE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wb_held_q, wb_held_d, md_held_q, md_held_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d, md_addr_q, md_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d, md_data_q, md_data_d;
    logic [DW-1:0] wb_pc_q, wb_pc_d, md_pc_q, md_pc_d;
    logic          md_older_q, md_older_d;
    logic [NR-1:0] busy_q, busy_d;

    logic grant_wb, grant_md, wb_acc, md_acc;

    // Grant: same-address entries drain oldest first, otherwise the FSM picks the winner.
    always_comb begin
        grant_wb = 1'b0;
        grant_md = 1'b0;
        if (wb_held_q && md_held_q) begin
            if (wb_addr_q == md_addr_q) begin
                grant_md = md_older_q;
                grant_wb = !md_older_q;
            end else if (state_q == MD_FORCE) begin
                grant_md = 1'b1;
            end else begin
                grant_wb = 1'b1;
            end
        end else begin
            grant_wb = wb_held_q;
            grant_md = md_held_q;
        end
    end

    assign wb_ready = reset && (!wb_held_q || grant_wb);
    assign md_ready = reset && (!md_held_q || grant_md);
    assign RegWrite = reset && (grant_wb || grant_md);
    assign RegAddr  = !reset ? '0 : grant_wb ? wb_addr_q : grant_md ? md_addr_q : '0;
    assign RegData  = !reset ? '0 : grant_wb ? wb_data_q : grant_md ? md_data_q : '0;
    assign PC       = !reset ? '0 : grant_wb ? wb_pc_q   : grant_md ? md_pc_q   : '0;
    assign busy     = reset ? busy_q : '0;

    // Writes to register 0 complete the handshake but are dropped here.
    assign wb_acc = wb_valid && wb_ready && (wb_addr != '0);
    assign md_acc = md_valid && md_ready && (md_addr != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_held_d  = wb_held_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        md_held_d  = md_held_q;
        md_addr_d  = md_addr_q;
        md_data_d  = md_data_q;
        md_pc_d    = md_pc_q;
        md_older_d = md_older_q;
        busy_d     = '0;

        if (grant_wb) wb_held_d = 1'b0;
        if (grant_md) md_held_d = 1'b0;
        if (wb_acc) begin
            wb_held_d = 1'b1;
            wb_addr_d = wb_addr;
            wb_data_d = wb_data;
            wb_pc_d   = wb_pc;
        end
        if (md_acc) begin
            md_held_d = 1'b1;
            md_addr_d = md_addr;
            md_data_d = md_data;
            md_pc_d   = md_pc;
        end

        // Same-edge acceptance counts as WB first.
        if (md_acc && !wb_acc)      md_older_d = !wb_held_d;
        else if (wb_acc && !md_acc) md_older_d = md_held_d;
        else if (wb_acc && md_acc)  md_older_d = 1'b0;

        if (md_held_q && !grant_md) cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        else                        cnt_d = '0;

        case (state_q)
            WB_PRIO:  if (cnt_d >= CW'(STARVE_LIMIT)) state_d = MD_FORCE;
            MD_FORCE: if (grant_md) state_d = WB_PRIO;
            default:  state_d = WB_PRIO;
        endcase

        for (int i = 1; i < NR; i++) begin
            busy_d[i] = (wb_held_d && (wb_addr_d == AW'(i))) ||
                        (md_held_d && (md_addr_d == AW'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= WB_PRIO;
            cnt_q      <= '0;
            wb_held_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
            md_held_q  <= 1'b0;
            md_addr_q  <= '0;
            md_data_q  <= '0;
            md_pc_q    <= '0;
            md_older_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_held_q  <= wb_held_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            md_held_q  <= md_held_d;
            md_addr_q  <= md_addr_d;
            md_data_q  <= md_data_d;
            md_pc_q    <= md_pc_d;
            md_older_q <= md_older_d;
            busy_q     <= busy_d;
        end
    end

`ifdef GRF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (RegWrite) $display("%d@%h: $%d <= %h", $time, PC, RegAddr, RegData);
    end
`else
`endif

endmodule
